// File: rtl/mips_cpu_mem_port.sv
// Load/store port between the multicycle MIPS core and an Avalon-MM bus:
// lane steering, load extension, alignment checks, optional pipelined reads and a bus timeout.
module mips_cpu_mem_port #(
  parameter int ADDR_W    = 32,
  parameter int PIPELINED = 0,
  parameter int TIMEOUT   = 256,
  parameter int TO_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic              memread,
  output logic              memwrite,
  input  logic              waitrequest,
  output logic [31:0]       memwritedata,
  output logic [3:0]        byteenable,
  input  logic [31:0]       memreaddata,
  input  logic              readdatavalid
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUS   = 2'd1;
  localparam logic [1:0] S_RDATA = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic            TO_EN   = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'd0:    lane_be = 4'b0001 << a;
      2'd1:    lane_be = a[1] ? 4'b1100 : 4'b0011;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'd0:    lane_wdata = {4{d[7:0]}};
      2'd1:    lane_wdata = {2{d[15:0]}};
      default: lane_wdata = d;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] d, input logic [1:0] sz,
                                               input logic [1:0] a, input logic sgn);
    logic [31:0] s;
    s = d >> {a, 3'b000};
    case (sz)
      2'd0:    load_extract = {{24{sgn & s[7]}}, s[7:0]};
      2'd1:    load_extract = {{16{sgn & s[15]}}, s[15:0]};
      default: load_extract = d;
    endcase
  endfunction

  logic [1:0]      state;
  logic [1:0]      size_q;
  logic [1:0]      lane_q;
  logic            signed_q;
  logic            write_q;
  logic [TO_W-1:0] to_cnt;
  logic            accept;
  logic            bad_req;
  logic            timed_out;
  logic [31:0]     rd_ext;

  assign accept    = req_valid && req_ready;
  assign bad_req   = (req_size == 2'd3) ||
                     ((req_size == 2'd1) && req_addr[0]) ||
                     ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
  assign timed_out = TO_EN && (to_cnt == TO_LAST);
  assign rd_ext    = load_extract(memreaddata, size_q, lane_q, signed_q);

  // Transaction FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_err      <= 1'b0;
      rsp_rdata    <= 32'h0;
      mem_address  <= '0;
      memread      <= 1'b0;
      memwrite     <= 1'b0;
      memwritedata <= 32'h0;
      byteenable   <= 4'b0000;
      size_q       <= 2'd0;
      lane_q       <= 2'd0;
      signed_q     <= 1'b0;
      write_q      <= 1'b0;
      to_cnt       <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            to_cnt    <= '0;
            rsp_rdata <= 32'h0;
            size_q    <= req_size;
            lane_q    <= req_addr[1:0];
            signed_q  <= req_signed;
            write_q   <= req_write;
            if (bad_req) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else begin
              state        <= S_BUS;
              mem_address  <= {req_addr[ADDR_W-1:2], 2'b00};
              byteenable   <= lane_be(req_size, req_addr[1:0]);
              memwritedata <= lane_wdata(req_size, req_wdata);
              memread      <= !req_write;
              memwrite     <= req_write;
            end
          end
        end
        S_BUS: begin
          to_cnt <= to_cnt + TO_W'(1);
          if (!waitrequest) begin
            memread  <= 1'b0;
            memwrite <= 1'b0;
            // A pipelined read completes here only if readdatavalid coincides with acceptance.
            if (write_q) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= 32'h0;
            end else if ((PIPELINED == 0) || readdatavalid) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= rd_ext;
            end else if (timed_out) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'h0;
            end else begin
              state <= S_RDATA;
            end
          end else if (timed_out) begin
            memread   <= 1'b0;
            memwrite  <= 1'b0;
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= 32'h0;
          end
        end
        S_RDATA: begin
          to_cnt <= to_cnt + TO_W'(1);
          if (readdatavalid) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= rd_ext;
          end else if (timed_out) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= 32'h0;
          end
        end
        S_RESP: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          memread   <= 1'b0;
          memwrite  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_mem_port.sv
// Directed bench: dut0 is non-pipelined, dut1 is pipelined with an 8-cycle timeout.
// Expected responses are queued at request time and popped when rsp_valid pulses.
module tb_mips_cpu_mem_port;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        waitrequest;
  logic [31:0] memreaddata;
  logic        readdatavalid;

  logic        req_valid0, req_ready0, rsp_valid0, rsp_err0, memread0, memwrite0;
  logic [31:0] rsp_rdata0, mem_address0, memwritedata0;
  logic [3:0]  byteenable0;
  logic        req_valid1, req_ready1, rsp_valid1, rsp_err1, memread1, memwrite1;
  logic [31:0] rsp_rdata1, mem_address1, memwritedata1;
  logic [3:0]  byteenable1;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;

  mips_cpu_mem_port #(.ADDR_W(32), .PIPELINED(0), .TIMEOUT(16), .TO_W(8)) dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid0),
    .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0), .mem_address(mem_address0),
    .memread(memread0), .memwrite(memwrite0), .waitrequest(waitrequest),
    .memwritedata(memwritedata0), .byteenable(byteenable0),
    .memreaddata(memreaddata), .readdatavalid(readdatavalid)
  );

  mips_cpu_mem_port #(.ADDR_W(32), .PIPELINED(1), .TIMEOUT(8), .TO_W(4)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid1),
    .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1), .mem_address(mem_address1),
    .memread(memread1), .memwrite(memwrite1), .waitrequest(waitrequest),
    .memwritedata(memwritedata1), .byteenable(byteenable1),
    .memreaddata(memreaddata), .readdatavalid(readdatavalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  // One dut0 transaction; waits = number of waitrequest-high cycles in BUS.
  task automatic txn0(input string tag, input logic wr, input logic [1:0] sz, input logic sg,
                      input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] bus_rd,
                      input int waits, input logic [3:0] exp_be, input logic [31:0] exp_wd,
                      input logic [31:0] exp_rd, input logic exp_err);
    int   lat;
    exp_t e;
    check({tag, ".ready"}, {31'd0, req_ready0}, 32'd1);
    req_valid0 = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wd; memreaddata = bus_rd; waitrequest = 1'b1;
    q0.push_back('{rd: exp_rd, err: exp_err});
    @(posedge clk); #1;
    req_valid0 = 1'b0;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (rsp_valid0) begin
        lat = c;
        break;
      end
      if (exp_err) begin
        check({tag, ".nostrobe"}, {30'd0, memread0, memwrite0}, 32'd0);
      end else begin
        check({tag, ".rd"}, {31'd0, memread0}, {31'd0, !wr});
        check({tag, ".wr"}, {31'd0, memwrite0}, {31'd0, wr});
        check({tag, ".addr"}, mem_address0, addr & 32'hFFFF_FFFC);
        check({tag, ".be"}, {28'd0, byteenable0}, {28'd0, exp_be});
        if (wr) check({tag, ".wdata"}, memwritedata0, exp_wd);
      end
      waitrequest = (c <= waits);
    end
    check({tag, ".lat"}, lat, exp_err ? 32'd1 : 32'(2 + waits));
    e = q0.pop_front();
    check({tag, ".rdata"}, rsp_rdata0, e.rd);
    check({tag, ".err"}, {31'd0, rsp_err0}, {31'd0, e.err});
    check({tag, ".busy"}, {31'd0, req_ready0}, 32'd0);
    @(posedge clk); #1;
    check({tag, ".pulse"}, {31'd0, rsp_valid0}, 32'd0);
    waitrequest = 1'b0;
  endtask

  // One dut1 pipelined load; rdv = cycle after accept carrying readdatavalid (-1 = never).
  task automatic pipe1(input string tag, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] bus_rd, input int rdv,
                       input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    int   lat;
    exp_t e;
    check({tag, ".ready"}, {31'd0, req_ready1}, 32'd1);
    req_valid1 = 1'b1; req_write = 1'b0; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = 32'h0; memreaddata = bus_rd;
    waitrequest = 1'b0; readdatavalid = 1'b0;
    q1.push_back('{rd: exp_rd, err: exp_err});
    @(posedge clk); #1;
    req_valid1 = 1'b0;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (rsp_valid1) begin
        lat = c;
        break;
      end
      check({tag, ".rd"}, {31'd0, memread1}, (c == 1) ? 32'd1 : 32'd0);
      if (c == 1) check({tag, ".addr"}, mem_address1, addr & 32'hFFFF_FFFC);
      readdatavalid = (c == rdv);
    end
    readdatavalid = 1'b0;
    check({tag, ".lat"}, lat, 32'(exp_lat));
    e = q1.pop_front();
    check({tag, ".rdata"}, rsp_rdata1, e.rd);
    check({tag, ".err"}, {31'd0, rsp_err1}, {31'd0, e.err});
    @(posedge clk); #1;
    check({tag, ".pulse"}, {31'd0, rsp_valid1}, 32'd0);
  endtask

  initial begin
    reset = 1'b0; req_valid0 = 1'b0; req_valid1 = 1'b0; req_write = 1'b0;
    req_size = 2'd0; req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    waitrequest = 1'b0; memreaddata = 32'h0; readdatavalid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.ready", {31'd0, req_ready0}, 32'd1);
    check("rst.rsp", {30'd0, rsp_valid0, rsp_err0}, 32'd0);
    check("rst.strobes", {30'd0, memread0, memwrite0}, 32'd0);
    check("rst.addr", mem_address0, 32'h0);
    check("rst.wdata", memwritedata0, 32'h0);
    check("rst.be", {28'd0, byteenable0}, 32'd0);
    check("rst.rdata", rsp_rdata0, 32'h0);
    check("rst.ready1", {31'd0, req_ready1}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    txn0("wload",   1'b0, 2'd2, 1'b0, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 0,
         4'b1111, 32'h0, 32'hDEAD_BEEF, 1'b0);
    txn0("sbyte",   1'b0, 2'd0, 1'b1, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0,
         4'b1000, 32'h0, 32'hFFFF_FF80, 1'b0);
    txn0("ubyte",   1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0,
         4'b1000, 32'h0, 32'h0000_0080, 1'b0);
    txn0("hstore",  1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'h1234_ABCD, 32'h5555_5555, 3,
         4'b1100, 32'hABCD_ABCD, 32'h0, 1'b0);
    txn0("misw",    1'b0, 2'd2, 1'b0, 32'h0000_2001, 32'h0, 32'h1111_1111, 0,
         4'b0000, 32'h0, 32'h0, 1'b1);
    txn0("shalf",   1'b0, 2'd1, 1'b1, 32'h0000_1002, 32'h0, 32'h8001_7FFF, 0,
         4'b1100, 32'h0, 32'hFFFF_8001, 1'b0);
    txn0("shalflo", 1'b0, 2'd1, 1'b1, 32'h0000_1000, 32'h0, 32'h8001_7FFF, 0,
         4'b0011, 32'h0, 32'h0000_7FFF, 1'b0);
    txn0("bstore",  1'b1, 2'd0, 1'b0, 32'h0000_3001, 32'hFFFF_FF5A, 32'h0, 1,
         4'b0010, 32'h5A5A_5A5A, 32'h0, 1'b0);
    txn0("size3",   1'b0, 2'd3, 1'b0, 32'h0000_3000, 32'h0, 32'h2222_2222, 0,
         4'b0000, 32'h0, 32'h0, 1'b1);
    txn0("mish",    1'b1, 2'd1, 1'b0, 32'h0000_1001, 32'h0000_BEEF, 32'h0, 0,
         4'b0000, 32'h0, 32'h0, 1'b1);
    txn0("wstore",  1'b1, 2'd2, 1'b0, 32'h0000_4004, 32'hCAFE_F00D, 32'h0, 2,
         4'b1111, 32'hCAFE_F00D, 32'h0, 1'b0);
    txn0("wload2",  1'b0, 2'd2, 1'b0, 32'h0000_400C, 32'h0, 32'h0BAD_CAFE, 2,
         4'b1111, 32'h0, 32'h0BAD_CAFE, 1'b0);

    pipe1("ptimeout", 2'd2, 1'b0, 32'h0000_0100, 32'h3333_3333, -1, 32'h0, 1'b1, 9);
    @(posedge clk); #1;
    readdatavalid = 1'b1;
    @(posedge clk); #1;
    readdatavalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("late.rsp", {31'd0, rsp_valid1}, 32'd0);
    end
    @(posedge clk); #1;
    pipe1("pload",  2'd2, 1'b0, 32'h0000_0104, 32'h1357_9BDF, 3, 32'h1357_9BDF, 1'b0, 4);
    pipe1("psame",  2'd1, 1'b1, 32'h0000_0102, 32'hF00D_1234, 1, 32'hFFFF_F00D, 1'b0, 2);
    pipe1("pbyte",  2'd0, 1'b0, 32'h0000_0101, 32'hF00D_A5C3, 5, 32'h0000_00A5, 1'b0, 6);

    req_valid0 = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h0000_4000; waitrequest = 1'b1;
    @(posedge clk); #1;
    req_valid0 = 1'b0;
    @(negedge clk);
    check("mrst.rd_before", {31'd0, memread0}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("mrst.rd_async", {31'd0, memread0}, 32'd0);
    check("mrst.rsp", {31'd0, rsp_valid0}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    waitrequest = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("mrst.norsp", {31'd0, rsp_valid0}, 32'd0);
      check("mrst.ready", {31'd0, req_ready0}, 32'd1);
    end
    @(posedge clk); #1;
    txn0("postrst", 1'b0, 2'd2, 1'b0, 32'h0000_5000, 32'h0, 32'h2468_ACE0, 0,
         4'b1111, 32'h0, 32'h2468_ACE0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_cpu_mem_port.md
Name: mips_cpu_mem_port

Overview:
Parametrised load/store port between the multicycle MIPS core and the Avalon-MM memory bus.
- Generalises the core's fixed word-only, waitrequest-stalled bus access:
  - byte, half and word access with lane steering and sign or zero extension;
  - alignment checking;
  - optional pipelined reads using readdatavalid;
  - bus timeout detection.
- One transaction outstanding at a time.
- The core issues a request, then waits for a one-cycle response pulse.

Parameters:
ADDR_W, 32, width of the byte address (minimum 3)
PIPELINED, 0, 0 = read data valid in the cycle memread is accepted (waitrequest low); 1 = read data returned later, flagged by readdatavalid
TIMEOUT, 256, maximum cycles in BUS or RDATA before aborting with error; 0 disables the timeout
TO_W, 16, width of the timeout counter; must satisfy TIMEOUT < 2**TO_W

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  core request strobe
req_ready  out  1  port can accept a request
req_write  in  1  1 = store, 0 = load
req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal
req_signed  in  1  sign-extend load result
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-justified
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  qualifies rsp_valid: misaligned, illegal size, or timeout
mem_address  out  ADDR_W  word-aligned bus address (low 2 bits always 0)
memread  out  1  Avalon read
memwrite  out  1  Avalon write
waitrequest  in  1  Avalon stall
memwritedata  out  32  lane-replicated store data
byteenable  out  4  active lanes
memreaddata  in  32  Avalon read data
readdatavalid  in  1  used only when PIPELINED = 1

Behaviour:
- All outputs are registered.
- Reset (reset low, asynchronous):
  - state IDLE; req_ready = 1;
  - rsp_valid, rsp_err, memread, memwrite = 0;
  - mem_address, memwritedata, rsp_rdata = 0; byteenable = 0;
  - timeout counter = 0.
- Reset asserted mid-transaction drops memread/memwrite immediately. No response is issued.
- States: IDLE, BUS, RDATA, RESP.
- IDLE:
  - req_ready = 1. A request is accepted when req_valid && req_ready.
  - Misaligned request (half with addr[0] = 1, word with addr[1:0] != 0) or size 3: go to RESP with err = 1. No bus cycle.
  - Otherwise go to BUS and register the bus outputs.
- Lane mapping (a = addr[1:0]):
  - byte: byteenable = 1 << a; memwritedata = {4{wdata[7:0]}}.
  - half: byteenable = a[1] ? 1100 : 0011; memwritedata = {2{wdata[15:0]}}.
  - word: byteenable = 1111; memwritedata = wdata.
- BUS:
  - memread or memwrite is held high. Address, byteenable and data stay stable while waitrequest = 1.
  - On the first cycle with waitrequest = 0, the strobe is accepted and deasserted at the next edge.
  - Write, or read with PIPELINED = 0: capture memreaddata in that cycle, then go to RESP.
  - Read with PIPELINED = 1: go to RDATA.
  - A readdatavalid arriving in the same cycle the read is accepted is captured and treated as completion.
- RDATA: wait for readdatavalid, capture memreaddata, go to RESP.
- Load extraction:
  - shift memreaddata right by 8*a;
  - take 8 or 16 bits;
  - extend with the sign bit if req_signed = 1, otherwise with zeros;
  - word loads pass through unmodified.
- Timeout:
  - counter clears on accept and increments each cycle in BUS or RDATA.
  - On reaching TIMEOUT (when nonzero): drop strobes, go to RESP with err = 1, rdata = 0.
  - A late readdatavalid in IDLE is ignored.
- RESP: rsp_valid = 1 for exactly one cycle, then IDLE. req_ready is 0 in BUS, RDATA and RESP.
- Latency (request accepted at edge N):
  - strobe first visible in cycle N+1;
  - zero-wait, non-pipelined access gives rsp_valid in cycle N+2;
  - each waitrequest cycle adds 1;
  - misaligned request gives rsp_valid in cycle N+1.
- Throughput: next request accepted no earlier than the rsp_valid cycle + 1.

Test Plan:
- Word load at 0x1000, waitrequest low, PIPELINED = 0, memreaddata = 0xDEADBEEF:
  - memread = 1 for 1 cycle at 0x1000, byteenable = 1111;
  - rsp_valid 2 cycles after accept, rsp_rdata = 0xDEADBEEF, err = 0.
- Signed byte load at 0x1003, memreaddata = 0x80FF1234: rsp_rdata = 0xFFFFFF80. Unsigned: 0x00000080.
- Half store 0xABCD to 0x2002 with waitrequest high for 3 cycles:
  - memwrite held 4 cycles with byteenable = 1100, memwritedata = 0xABCDABCD, mem_address = 0x2000 stable;
  - single rsp_valid.
- Word load at 0x2001: no memread; rsp_valid with rsp_err = 1 in the cycle after accept.
- PIPELINED = 1, TIMEOUT = 8, readdatavalid never asserted: rsp_err = 1 after 8 cycles in BUS/RDATA; a subsequent load completes normally.
- Assert reset low while waitrequest is held high in BUS: memread drops asynchronously, no rsp_valid, req_ready = 1 after reset release.
